latch_stim_gen: RTL and testbench
=================================

// Module: latch_stim_gen
// PURPOSE
//  Synthesizable driver/checker for the d_latch interface (d, en, rstn -> q).
//  Holds the latch in reset, then for NUM_ITER iterations toggles en and drives
//  d <= iter[0] after LFSR-random cycle delays, checking q against a reference
//  latch model every cycle. Used for on-board latch self-test; reports pass/fail.
// PARAMETERS
//  NUM_ITER   5        iterations per run (1..255)
//  RST_CYC    10       cycles rstn_o held low after start (1..255)
//  LFSR_SEED  16'hACE1 LFSR load value on rst/start; 16'h0000 is replaced by 16'h0001
// PORTS
//  clk       in   1  clock, rising-edge
//  rst       in   1  synchronous active-high reset
//  start     in   1  1-cycle pulse; begins a run when IDLE or DONE, ignored when busy
//  q_i       in   1  latch output q
//  d_o       out  1  latch d
//  en_o      out  1  latch en
//  rstn_o    out  1  latch active-low reset
//  busy      out  1  high from cycle after accepted start until DONE
//  done      out  1  high in DONE state, held until next start or rst
//  pass      out  1  valid when done: 1 iff err_cnt == 0
//  err_cnt   out  8  mismatch count, saturates at 255
//  iter_cnt  out  8  completed iterations
// BEHAVIOUR
//  Reset (rst=1 at edge): d_o=0, en_o=0, rstn_o=0, busy=0, done=0, pass=0,
//   err_cnt=0, iter_cnt=0, LFSR=seed, state=IDLE. rst overrides all, mid-run too.
//  LFSR: 16-bit Galois, mask 16'hB400, right shift; steps once per iteration draw.
//  FSM:
//   IDLE   : outputs hold; start -> RSTH (clear err_cnt/iter_cnt/done/pass, load
//            seed, d_o=0, en_o=0, rstn_o=0, timer=RST_CYC-1).
//   RSTH   : rstn_o=0; timer==0 -> rstn_o<=1, -> DRAW; else timer--.
//   DRAW   : LFSR steps; dly2<=new lfsr[1:0], dly<=new lfsr[4:2]; -> WEN.
//   WEN    : wait dly2 cycles (0 = none); then en_o<=~en_o, -> WD.
//   WD     : wait dly cycles (0 = none); then d_o<=iter_cnt[0], -> NEXT.
//   NEXT   : iter_cnt++; if iter_cnt+1==NUM_ITER -> DONE else -> DRAW.
//   DONE   : done=1, busy=0, pass=(err_cnt==0); start -> RSTH as from IDLE.
//  Output latency: each drive change appears on the edge leaving its state.
//  Iteration length = 2 + dly2 + dly + 1 cycles (min 3, max 13).
//  Check model: exp = !rstn_o ? 0 : en_o ? d_o : exp_q; exp_q <= exp each cycle
//   (exp_q=0 on rst). Compare q_i vs exp every cycle while busy (RSTH..NEXT);
//   mismatch -> err_cnt++ unless 255. No compare in IDLE/DONE.
//  start while busy: ignored. start and rst same cycle: rst wins.
//  en_o is not reset between iterations: it toggles from its current value.
// TESTING
//  1 Ideal latch model on q_i, seed ACE1, NUM_ITER=5, start -> rstn_o low exactly
//    10 cycles, 5 en_o toggles, done=1, pass=1, err_cnt=0, iter_cnt=5.
//  2 q_i tied 0 -> err_cnt = count of busy cycles where exp=1, pass=0.
//  3 q_i tied 1, NUM_ITER=255, RST_CYC=255 -> err_cnt saturates at 255, no wrap.
//  4 Assert rst mid-WD -> next cycle all outputs at reset values, state IDLE.
//  5 start pulses while busy -> no restart; run length identical to case 1.
//  6 LFSR_SEED=0 -> behaves as seed 0001; DRAW sequence matches software model.

Source files
------------

// File: rtl/latch_stim_gen_if.sv
// Latch-side bundle between the stimulus generator (master) and the latch under test (slave).
interface latch_stim_gen_if;
  logic d_o;
  logic en_o;
  logic rstn_o;
  logic q_i;

  modport master (output d_o, en_o, rstn_o, input q_i);
  modport slave  (input d_o, en_o, rstn_o, output q_i);
endinterface

// File: rtl/latch_stim_gen.sv
// Latch self-test: holds the latch in reset, then toggles en and drives d after LFSR-random delays,
// checking q against a reference latch every busy cycle. Drive changes land on the edge leaving a state.
module latch_stim_gen #(
  parameter int unsigned NUM_ITER  = 5,
  parameter int unsigned RST_CYC   = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  latch_stim_gen_if.master lat,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_cnt,
  output logic [7:0]       iter_cnt
);
  localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [7:0]  ITER_LAST = 8'(NUM_ITER - 1);
  localparam logic [7:0]  RST_LOAD  = 8'(RST_CYC - 1);

  typedef enum logic [2:0] {IDLE, RSTH, DRAW, WEN, WD, NEXT, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] lfsr, lfsr_nxt;
  logic [7:0]  timer;
  logic [2:0]  dly;
  logic [1:0]  dly2_new;
  logic [2:0]  dly_new;
  logic        d_r, en_r, rstn_r;
  logic        exp_q, exp_now, mismatch;

  assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign dly2_new = lfsr_nxt[1:0];
  assign dly_new  = lfsr_nxt[4:2];

  assign lat.d_o    = d_r;
  assign lat.en_o   = en_r;
  assign lat.rstn_o = rstn_r;

  assign exp_now  = !rstn_r ? 1'b0 : (en_r ? d_r : exp_q);
  assign mismatch = (lat.q_i != exp_now);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A zero en-delay skips WEN entirely: the toggle happens on the edge leaving DRAW.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = RSTH;
      RSTH:       if (timer == 8'd0) state_nxt = DRAW;
      DRAW:       state_nxt = (dly2_new == 2'd0) ? WD : WEN;
      WEN:        if (timer == 8'd0) state_nxt = WD;
      WD:         if (timer == 8'd0) state_nxt = NEXT;
      NEXT:       state_nxt = (iter_cnt == ITER_LAST) ? DONE : DRAW;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RSTH, DRAW, WEN, WD, NEXT: busy = 1'b1;
      DONE:                      done = 1'b1;
      default:                   ;
    endcase
    pass = done && (err_cnt == 8'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_r      <= 1'b0;
      en_r     <= 1'b0;
      rstn_r   <= 1'b0;
      err_cnt  <= 8'd0;
      iter_cnt <= 8'd0;
      lfsr     <= SEED;
      timer    <= 8'd0;
      dly      <= 3'd0;
      exp_q    <= 1'b0;
    end else begin
      exp_q <= exp_now;
      if (busy && mismatch && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      case (state)
        IDLE, DONE: if (start) begin
          err_cnt  <= 8'd0;
          iter_cnt <= 8'd0;
          lfsr     <= SEED;
          d_r      <= 1'b0;
          en_r     <= 1'b0;
          rstn_r   <= 1'b0;
          timer    <= RST_LOAD;
        end
        RSTH: begin
          if (timer == 8'd0) rstn_r <= 1'b1;
          else               timer  <= timer - 8'd1;
        end
        DRAW: begin
          lfsr <= lfsr_nxt;
          dly  <= dly_new;
          if (dly2_new == 2'd0) begin
            en_r  <= ~en_r;
            timer <= {5'd0, dly_new};
          end else begin
            timer <= {6'd0, dly2_new} - 8'd1;
          end
        end
        WEN: begin
          if (timer == 8'd0) begin
            en_r  <= ~en_r;
            timer <= {5'd0, dly};
          end else begin
            timer <= timer - 8'd1;
          end
        end
        WD: begin
          if (timer == 8'd0) d_r   <= iter_cnt[0];
          else               timer <= timer - 8'd1;
        end
        NEXT:    iter_cnt <= iter_cnt + 8'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_latch_stim_gen.sv
// Bench for latch_stim_gen: three instances (default, long saturating run, zero seed) checked
// against a cycle-timeline model built from the iteration rules and an ideal latch.
module tb_latch_stim_gen;
  logic       clk = 1'b0;
  logic [2:0] rst_v = 3'b111;
  logic [2:0] start_v = 3'b000;
  logic       busy_v [3];
  logic       done_v [3];
  logic       pass_v [3];
  logic [7:0] err_v  [3];
  logic [7:0] iter_v [3];
  int         sel = 0;
  int         qmode = 0;
  int         total = 0;
  int         badn = 0;
  logic       lq_a, lq_c;
  logic       obs_d, obs_en, obs_rstn, obs_busy, obs_done, obs_pass;
  logic [7:0] obs_err, obs_iter;

  bit ed[$];
  bit een[$];
  bit ern[$];
  int m_len, m_err, m_niter, m_rst, m_wd;

  always #5 clk = ~clk;

  latch_stim_gen_if ifa();
  latch_stim_gen_if ifb();
  latch_stim_gen_if ifc();

  latch_stim_gen u_a (.clk(clk), .rst(rst_v[0]), .start(start_v[0]), .lat(ifa),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_cnt(err_v[0]), .iter_cnt(iter_v[0]));
  latch_stim_gen #(.NUM_ITER(255), .RST_CYC(255)) u_b (.clk(clk), .rst(rst_v[1]), .start(start_v[1]),
    .lat(ifb), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_cnt(err_v[1]), .iter_cnt(iter_v[1]));
  latch_stim_gen #(.NUM_ITER(6), .RST_CYC(3), .LFSR_SEED(16'h0000)) u_c (.clk(clk), .rst(rst_v[2]),
    .start(start_v[2]), .lat(ifc), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .err_cnt(err_v[2]), .iter_cnt(iter_v[2]));

  // Ideal transparent-high latch with active-low clear.
  always_latch begin
    if (!ifa.rstn_o)   lq_a = 1'b0;
    else if (ifa.en_o) lq_a = ifa.d_o;
  end
  always_latch begin
    if (!ifc.rstn_o)   lq_c = 1'b0;
    else if (ifc.en_o) lq_c = ifc.d_o;
  end

  assign ifa.q_i = (qmode == 0) ? lq_a : (qmode == 2);
  assign ifb.q_i = 1'b1;
  assign ifc.q_i = lq_c;

  always_comb begin
    obs_d = ifa.d_o; obs_en = ifa.en_o; obs_rstn = ifa.rstn_o;
    if (sel == 1) begin
      obs_d = ifb.d_o; obs_en = ifb.en_o; obs_rstn = ifb.rstn_o;
    end else if (sel == 2) begin
      obs_d = ifc.d_o; obs_en = ifc.en_o; obs_rstn = ifc.rstn_o;
    end
    obs_busy = busy_v[sel];
    obs_done = done_v[sel];
    obs_pass = pass_v[sel];
    obs_err  = err_v[sel];
    obs_iter = iter_v[sel];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      badn++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Expected per-busy-cycle drive values, run length and saturated error count.
  task automatic build_model(input logic [15:0] seed, input int niter, input int rstcyc, input int qm);
    logic [15:0] s;
    bit d, en, hold, e;
    int a, b, errs;
    s = (seed == 16'h0000) ? 16'h0001 : seed;
    d = 1'b0; en = 1'b0;
    ed.delete(); een.delete(); ern.delete();
    for (int k = 0; k < rstcyc; k++) begin
      ed.push_back(1'b0); een.push_back(1'b0); ern.push_back(1'b0);
    end
    for (int i = 0; i < niter; i++) begin
      s = lfsr_step(s);
      a = int'(s[1:0]);
      b = int'(s[4:2]);
      if (i == 0) m_wd = rstcyc + 1 + a;
      for (int j = 0; j < a + b + 3; j++) begin
        een.push_back((j <= a) ? en : ~en);
        ed.push_back((j == a + b + 2) ? i[0] : d);
        ern.push_back(1'b1);
      end
      en = ~en;
      d  = i[0];
    end
    hold = 1'b0; errs = 0;
    for (int n = 0; n < ed.size(); n++) begin
      e = !ern[n] ? 1'b0 : (een[n] ? ed[n] : hold);
      hold = e;
      if (qm != 0 && e != (qm == 2)) errs++;
    end
    m_len = ed.size();
    m_err = (errs > 255) ? 255 : errs;
    m_niter = niter;
    m_rst = rstcyc;
  endtask

  task automatic do_start();
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
  endtask

  // Called on the first busy cycle; walks the run and optionally pulses start while busy.
  task automatic check_run(input string tag, input bit poke);
    int n, dev, tog, rl;
    bit pen;
    n = 0; dev = 0; tog = 0; rl = 0; pen = 1'b0;
    while (obs_busy === 1'b1 && n < 20000) begin
      start_v[sel] = poke && (n % 7 == 3);
      if (n < m_len) begin
        if (obs_d !== ed[n] || obs_en !== een[n] || obs_rstn !== ern[n]) dev++;
      end else begin
        dev++;
      end
      if (n > 0 && obs_en !== pen) tog++;
      if (obs_rstn === 1'b0) rl++;
      pen = obs_en;
      n++;
      @(negedge clk);
    end
    start_v[sel] = 1'b0;
    chk({tag, " len"}, n, m_len);
    chk({tag, " trace"}, dev, 0);
    chk({tag, " rstlow"}, rl, m_rst);
    chk({tag, " toggles"}, tog, m_niter);
    chk({tag, " done"}, 32'(obs_done), 1);
    chk({tag, " err"}, 32'(obs_err), m_err);
    chk({tag, " pass"}, 32'(obs_pass), (m_err == 0) ? 1 : 0);
    chk({tag, " iter"}, 32'(obs_iter), m_niter);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_v = 3'b000;
    chk("reset outs", 32'({obs_d, obs_en, obs_rstn, obs_busy, obs_done, obs_pass}), 0);
    chk("reset err", 32'(obs_err), 0);
    chk("reset iter", 32'(obs_iter), 0);
    repeat (3) @(negedge clk);
    chk("idle hold", 32'({obs_busy, obs_done}), 0);

    qmode = 0;
    build_model(16'hACE1, 5, 10, 0);
    do_start();
    check_run("ideal", 1'b0);
    repeat (5) @(negedge clk);
    chk("done held", 32'({obs_done, obs_pass}), 32'h3);

    build_model(16'hACE1, 5, 10, 0);
    do_start();
    check_run("poke", 1'b1);

    qmode = 1;
    build_model(16'hACE1, 5, 10, 1);
    do_start();
    check_run("q0", 1'b0);

    for (int r = 0; r < 3; r++) begin
      qmode = $urandom_range(0, 2);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      build_model(16'hACE1, 5, 10, qmode);
      do_start();
      check_run($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)));
    end

    qmode = 0;
    build_model(16'hACE1, 5, 10, 0);
    do_start();
    repeat (m_wd) @(negedge clk);
    chk("pre-rst busy", 32'(obs_busy), 1);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    chk("midrst outs", 32'({obs_d, obs_en, obs_rstn, obs_busy, obs_done, obs_pass}), 0);
    chk("midrst err", 32'(obs_err), 0);
    chk("midrst iter", 32'(obs_iter), 0);
    repeat (3) @(negedge clk);
    chk("midrst idle", 32'({obs_busy, obs_done}), 0);

    rst_v[0] = 1'b1;
    start_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    start_v[0] = 1'b0;
    @(negedge clk);
    chk("rst beats start", 32'(obs_busy), 0);

    build_model(16'hACE1, 5, 10, 0);
    do_start();
    check_run("after rst", 1'b0);

    sel = 1;
    build_model(16'hACE1, 255, 255, 2);
    do_start();
    check_run("sat", 1'b0);

    sel = 2;
    build_model(16'h0001, 6, 3, 0);
    do_start();
    check_run("seed0", 1'b0);

    $display("test done: total=%0d bad=%0d", total, badn);
    $finish;
  end
endmodule
